// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types, constants and helpers for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned DEF_REG_W      = 5;
    localparam int unsigned DEF_MULDIV_LAT = 32;
    localparam int unsigned DEF_CNT_W      = 6;
    localparam int unsigned PERF_W         = 32;
    localparam int unsigned REG_ZERO       = 0;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_BUSY = 1'b1
    } muldiv_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_flush;
        logic exmem_write;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam stage_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam stage_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam stage_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Bubbles are loaded into IF/ID and ID/EX while the pipeline is held in reset.
    localparam stage_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v,
                                                  input logic              en);
        return (en && (v != '1)) ? v + PERF_W'(1) : v;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_muldiv_busy_tracker.sv
// Tracks HI/LO occupancy: busy for exactly MULDIV_LAT cycles after a MULT/DIV issues.
module muldiv_busy_tracker
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = DEF_MULDIV_LAT,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic issue_i,
    output logic busy_o
);

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= M_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter runs unconditionally in M_BUSY so memory freezes do not extend occupancy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            M_IDLE: begin
                if (issue_i) begin
                    state_d = M_BUSY;
                    cnt_d   = CNT_W'(MULDIV_LAT - 1);
                end
            end
            M_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = M_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = M_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o = (state_q == M_BUSY);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline with saturating perf counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W      = DEF_REG_W,
    parameter int unsigned MULDIV_LAT = DEF_MULDIV_LAT,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_muldiv,
    input  logic              id_reads_hilo,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_flush,
    output logic              exmem_write,
    output logic              muldiv_busy,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
);

    logic        freeze, branch, loaduse, hilo_hz, stall, issue;
    stage_ctrl_t ctrl;

    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] flush_events_q, flush_events_d;

    assign freeze  = mem_req & ~mem_ready;
    assign branch  = ex_branch_taken & ~freeze;
    // $zero as a load destination never carries a value, so it cannot create a hazard.
    assign loaduse = ex_mem_read & (ex_rd != REG_W'(REG_ZERO)) &
                     ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
    assign hilo_hz = muldiv_busy & (id_reads_hilo | id_muldiv);
    assign stall   = (loaduse | hilo_hz) & ~branch & ~freeze;
    assign issue   = id_muldiv & ~stall & ~branch & ~freeze;

    muldiv_busy_tracker #(
        .MULDIV_LAT (MULDIV_LAT),
        .CNT_W      (CNT_W)
    ) u_muldiv_busy_tracker (
        .clock   (clock),
        .reset   (reset),
        .issue_i (issue),
        .busy_o  (muldiv_busy)
    );

    // Priority: reset > freeze > branch > stall > normal.
    always_comb begin
        ctrl = CTRL_NORMAL;
        if (reset) begin
            ctrl = CTRL_RESET;
        end else if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (branch) begin
            ctrl = CTRL_BRANCH;
        end else if (stall) begin
            ctrl = CTRL_STALL;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_write  = ctrl.idex_write;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_write = ctrl.exmem_write;

    always_comb begin
        stall_cycles_d = sat_inc(stall_cycles_q, stall | freeze);
        flush_events_d = sat_inc(flush_events_q, branch);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver queues per-cycle expectations, monitor checks.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_W = 5;

    // Control word order: {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write}
    localparam logic [5:0] N = 6'b110101;
    localparam logic [5:0] S = 6'b000111;
    localparam logic [5:0] B = 6'b111111;
    localparam logic [5:0] F = 6'b000000;
    localparam logic [5:0] R = 6'b001010;

    typedef struct {
        logic [5:0]  ctrl;
        logic        busy;
        logic [31:0] sc;
        logic [31:0] fe;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_uses_rs, id_uses_rt, id_muldiv, id_reads_hilo;
    logic             ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;
    logic             muldiv_busy;
    logic [31:0]      stall_cycles, flush_events;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_W      (REG_W),
        .MULDIV_LAT (4),
        .CNT_W      (6)
    ) dut (
        .clock           (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_muldiv       (id_muldiv),
        .id_reads_hilo   (id_reads_hilo),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_write      (idex_write),
        .idex_flush      (idex_flush),
        .exmem_write     (exmem_write),
        .muldiv_busy     (muldiv_busy),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    task automatic clr();
        reset = 1'b0; id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_muldiv = 1'b0; id_reads_hilo = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic step(input string nm, input logic [5:0] ec, input logic eb,
                        input logic [31:0] es, input logic [31:0] ef);
        exp_t e;
        e.ctrl = ec; e.busy = eb; e.sc = es; e.fe = ef;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic set_loaduse(input logic [REG_W-1:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs = rd; id_uses_rs = 1'b1;
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t       e;
        string      nm;
        logic [5:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write};
            total++;
            if (act !== e.ctrl) begin
                bad++;
                $display("FAIL %s ctrl: got %b want %b", nm, act, e.ctrl);
            end
            total++;
            if (muldiv_busy !== e.busy) begin
                bad++;
                $display("FAIL %s busy: got %b want %b", nm, muldiv_busy, e.busy);
            end
            total++;
            if (stall_cycles !== e.sc) begin
                bad++;
                $display("FAIL %s stall_cycles: got %h want %h", nm, stall_cycles, e.sc);
            end
            total++;
            if (flush_events !== e.fe) begin
                bad++;
                $display("FAIL %s flush_events: got %h want %h", nm, flush_events, e.fe);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        clr();
        reset = 1'b1;
        @(posedge clk);
        #1;
        // reset holds bubbles
        reset = 1'b1; step("rst0", R, 1'b0, 32'd0, 32'd0);
        reset = 1'b1; step("rst1", R, 1'b0, 32'd0, 32'd0);
        // load-use on rs, then release
        clr(); set_loaduse(5'd8);                        step("lu_stall", S, 1'b0, 32'd0, 32'd0);
        clr();                                           step("lu_after", N, 1'b0, 32'd1, 32'd0);
        // $zero load never stalls
        clr(); set_loaduse(5'd0); id_uses_rt = 1'b1;     step("zero_rd", N, 1'b0, 32'd1, 32'd0);
        // branch wins over load-use
        clr(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
        ex_branch_taken = 1'b1;                          step("br_lu", B, 1'b0, 32'd1, 32'd0);
        clr();                                           step("br_after", N, 1'b0, 32'd1, 32'd1);
        // rt match stalls; unused rs does not
        clr(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
                                                         step("lu_rt", S, 1'b0, 32'd1, 32'd1);
        clr(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
                                                         step("no_use", N, 1'b0, 32'd2, 32'd1);
        // MULT then MFLO stalled 4 cycles
        clr(); id_muldiv = 1'b1;                         step("mult_iss", N, 1'b0, 32'd2, 32'd1);
        clr(); id_reads_hilo = 1'b1;                     step("mflo_st1", S, 1'b1, 32'd2, 32'd1);
        clr(); id_reads_hilo = 1'b1;                     step("mflo_st2", S, 1'b1, 32'd3, 32'd1);
        clr(); id_reads_hilo = 1'b1;                     step("mflo_st3", S, 1'b1, 32'd4, 32'd1);
        clr(); id_reads_hilo = 1'b1;                     step("mflo_st4", S, 1'b1, 32'd5, 32'd1);
        clr(); id_reads_hilo = 1'b1;                     step("mflo_go", N, 1'b0, 32'd6, 32'd1);
        // independent ADD during busy, second DIV waits for busy to drop
        clr(); id_muldiv = 1'b1;                         step("mult2_iss", N, 1'b0, 32'd6, 32'd1);
        clr(); id_rs = 5'd3; id_uses_rs = 1'b1;          step("add_busy", N, 1'b1, 32'd6, 32'd1);
        clr(); id_muldiv = 1'b1;                         step("div_st1", S, 1'b1, 32'd6, 32'd1);
        clr(); id_muldiv = 1'b1;                         step("div_st2", S, 1'b1, 32'd7, 32'd1);
        clr(); id_muldiv = 1'b1;                         step("div_st3", S, 1'b1, 32'd8, 32'd1);
        clr(); id_muldiv = 1'b1;                         step("div_iss", N, 1'b0, 32'd9, 32'd1);
        clr();                                           step("div_b1", N, 1'b1, 32'd9, 32'd1);
        clr();                                           step("div_b2", N, 1'b1, 32'd9, 32'd1);
        clr();                                           step("div_b3", N, 1'b1, 32'd9, 32'd1);
        clr();                                           step("div_b4", N, 1'b1, 32'd9, 32'd1);
        clr();                                           step("div_done", N, 1'b0, 32'd9, 32'd1);
        // memory freeze holds a taken branch until release
        clr(); mem_req = 1'b1; ex_branch_taken = 1'b1;   step("frz1", F, 1'b0, 32'd9, 32'd1);
        clr(); mem_req = 1'b1; ex_branch_taken = 1'b1;   step("frz2", F, 1'b0, 32'd10, 32'd1);
        clr(); mem_req = 1'b1; ex_branch_taken = 1'b1;   step("frz3", F, 1'b0, 32'd11, 32'd1);
        clr(); mem_req = 1'b1; mem_ready = 1'b1; ex_branch_taken = 1'b1;
                                                         step("frz_rel", B, 1'b0, 32'd12, 32'd1);
        clr();                                           step("frz_after", N, 1'b0, 32'd12, 32'd2);
        // busy counter keeps running through a freeze
        clr(); id_muldiv = 1'b1;                         step("mult3_iss", N, 1'b0, 32'd12, 32'd2);
        clr(); mem_req = 1'b1;                           step("frzb1", F, 1'b1, 32'd12, 32'd2);
        clr(); mem_req = 1'b1;                           step("frzb2", F, 1'b1, 32'd13, 32'd2);
        clr();                                           step("frzb_b3", N, 1'b1, 32'd14, 32'd2);
        clr();                                           step("frzb_b4", N, 1'b1, 32'd14, 32'd2);
        clr();                                           step("frzb_done", N, 1'b0, 32'd14, 32'd2);
        // no issue under freeze or branch
        clr(); mem_req = 1'b1; id_muldiv = 1'b1;         step("frz_md", F, 1'b0, 32'd14, 32'd2);
        clr();                                           step("frz_md_chk", N, 1'b0, 32'd15, 32'd2);
        clr(); ex_branch_taken = 1'b1; id_muldiv = 1'b1; step("br_md", B, 1'b0, 32'd15, 32'd2);
        clr();                                           step("br_md_chk", N, 1'b0, 32'd15, 32'd3);
        // reset in the middle of a MULT
        clr(); id_muldiv = 1'b1;                         step("mult4_iss", N, 1'b0, 32'd15, 32'd3);
        clr(); id_reads_hilo = 1'b1;                     step("mflo4_st1", S, 1'b1, 32'd15, 32'd3);
        clr(); id_reads_hilo = 1'b1;                     step("mflo4_st2", S, 1'b1, 32'd16, 32'd3);
        clr(); id_reads_hilo = 1'b1; reset = 1'b1;       step("rst_mid0", R, 1'b1, 32'd17, 32'd3);
        clr(); id_reads_hilo = 1'b1; reset = 1'b1;       step("rst_mid1", R, 1'b0, 32'd0, 32'd0);
        clr(); id_reads_hilo = 1'b1;                     step("mflo_post", N, 1'b0, 32'd0, 32'd0);
        clr();                                           step("post_idle", N, 1'b0, 32'd0, 32'd0);
        // saturation of the stall counter
        clr();
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        step("sat_pre", N, 1'b0, 32'hFFFF_FFFE, 32'd0);
        release dut.stall_cycles_q;
        clr(); set_loaduse(5'd4);                        step("sat1", S, 1'b0, 32'hFFFF_FFFE, 32'd0);
        clr(); set_loaduse(5'd4);                        step("sat2", S, 1'b0, 32'hFFFF_FFFF, 32'd0);
        clr(); set_loaduse(5'd4);                        step("sat3", S, 1'b0, 32'hFFFF_FFFF, 32'd0);
        clr();                                           step("sat_hold", N, 1'b0, 32'hFFFF_FFFF, 32'd0);

        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
